data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder_if.sv | 28 ++
 rtl/data_mem_responder.sv | 173 +++++++++++++++++
 tb/tb_data_mem_responder.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_responder_if.sv
`default_nettype none
// =============================================================================
// Module   : data_mem_responder_if
// Brief    : CPU-side load/store request/response bundle for data_mem_responder.
// Revision : 1.0 - initial release
// =============================================================================
interface data_mem_responder_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;
    logic        busy;
    logic        addr_err;

    modport master (
        output req, wr, size, addr, wdata,
        input  ack, rdata, busy, addr_err
    );

    modport slave (
        input  req, wr, size, addr, wdata,
        output ack, rdata, busy, addr_err
    );
endinterface
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// =============================================================================
// Module   : data_mem_responder
// Brief    : Wait-stated 32-bit data memory with byte/half/word load-store.
// Revision : 1.0 - initial release
// =============================================================================
module data_mem_responder #(
    parameter int WAIT_CYCLES = 2,
    parameter int DEPTH_LOG2  = 8
) (
    input  wire logic           clk,
    input  wire logic           reset,
    data_mem_responder_if.slave bus
);

    localparam int         c_depth     = 1 << DEPTH_LOG2;
    localparam logic [3:0] c_wait_load = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;

    logic                    r_wr;
    logic [1:0]              r_size;
    logic [DEPTH_LOG2+1:0]   r_addr;
    logic [31:0]             r_wdata;
    logic [3:0]              r_cnt;
    logic                    r_ack;
    logic                    r_busy;
    logic                    r_addr_err;
    logic [31:0]             r_rdata;
    logic [31:0]             r_mem [c_depth];

    logic                    w_misaligned;
    logic                    w_start;
    logic [DEPTH_LOG2-1:0]   w_idx;
    logic [4:0]              w_shift;
    logic [31:0]             w_word;
    logic [31:0]             w_load;
    logic [31:0]             w_merge;
    logic                    w_we;
    logic                    w_addr_unused;

    // Address bits above the array are deliberately ignored so accesses wrap.
    assign w_addr_unused = ^bus.addr[31:DEPTH_LOG2+2];

    always_comb begin
        w_misaligned = 1'b0;
        case (bus.size)
            2'b00:   w_misaligned = (bus.addr[1:0] != 2'b00);
            2'b01:   w_misaligned = bus.addr[0];
            2'b10:   w_misaligned = 1'b0;
            default: w_misaligned = 1'b1;
        endcase
    end

    assign w_start = (r_state == S_IDLE) && bus.req;
    assign w_idx   = r_addr[DEPTH_LOG2+1:2];
    assign w_shift = {r_addr[1:0], 3'b000};
    assign w_word  = r_mem[w_idx];
    assign w_we    = (r_state == S_ACCESS) && r_wr && !reset;

    // Lane extraction for loads and read-modify-write merge for stores.
    always_comb begin
        w_load  = w_word;
        w_merge = r_wdata;
        case (r_size)
            2'b01: begin
                w_load  = r_addr[1] ? {16'd0, w_word[31:16]} : {16'd0, w_word[15:0]};
                w_merge = r_addr[1] ? {r_wdata[15:0], w_word[15:0]}
                                    : {w_word[31:16], r_wdata[15:0]};
            end
            2'b10: begin
                w_load  = {24'd0, 8'(w_word >> w_shift)};
                w_merge = (w_word & ~(32'h0000_00FF << w_shift))
                        | ({24'd0, r_wdata[7:0]} << w_shift);
            end
            default: begin
                w_load  = w_word;
                w_merge = r_wdata;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_idx] <= w_merge;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.req) begin
                    if (w_misaligned) begin
                        w_state_nxt = S_RESP;
                    end else if (WAIT_CYCLES == 0) begin
                        w_state_nxt = S_ACCESS;
                    end else begin
                        w_state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = S_ACCESS;
                end
            end
            S_ACCESS: w_state_nxt = S_RESP;
            S_RESP:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr       <= 1'b0;
            r_size     <= 2'b00;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_cnt      <= 4'd0;
            r_ack      <= 1'b0;
            r_busy     <= 1'b0;
            r_addr_err <= 1'b0;
            r_rdata    <= '0;
        end else begin
            r_ack      <= (w_state_nxt == S_RESP);
            r_busy     <= (w_state_nxt != S_IDLE);
            r_addr_err <= w_start && w_misaligned;

            if (w_start) begin
                r_wr    <= bus.wr;
                r_size  <= bus.size;
                r_addr  <= bus.addr[DEPTH_LOG2+1:0];
                r_wdata <= bus.wdata;
            end

            if ((w_state_nxt == S_WAIT) && (r_state != S_WAIT)) begin
                r_cnt <= c_wait_load;
            end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end

            if (w_start && w_misaligned) begin
                r_rdata <= '0;
            end else if ((r_state == S_ACCESS) && !r_wr) begin
                r_rdata <= w_load;
            end
        end
    end

    assign bus.ack      = r_ack;
    assign bus.busy     = r_busy;
    assign bus.addr_err = r_addr_err;
    assign bus.rdata    = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// =============================================================================
// Module   : tb_data_mem_responder
// Brief    : Self-checking bench: byte-level memory model, directed + random ops.
// Revision : 1.0 - initial release
// =============================================================================
module tb_data_mem_responder;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    data_mem_responder_if ifa ();
    data_mem_responder_if ifb ();

    data_mem_responder #(.WAIT_CYCLES(2), .DEPTH_LOG2(8)) u_dut_a (
        .clk   (clk),
        .reset (rst_a),
        .bus   (ifa)
    );

    data_mem_responder #(.WAIT_CYCLES(0), .DEPTH_LOG2(8)) u_dut_b (
        .clk   (clk),
        .reset (rst_b),
        .bus   (ifb)
    );

    // Reference: byte-addressed memory per DUT plus the last rdata each returned.
    logic [7:0]  mdl [2][1024];
    logic [31:0] exp_rd [2];

    function automatic bit model_mis(input logic [1:0] size, input logic [31:0] addr);
        int nbytes = (size == 2'b00) ? 4 : (size == 2'b01) ? 2 : 1;
        if (size == 2'b11) return 1'b1;
        return (addr % nbytes) != 0;
    endfunction

    function automatic logic [31:0] model_load(input int sel, input logic [1:0] size,
                                               input logic [31:0] addr);
        int          nbytes = (size == 2'b00) ? 4 : (size == 2'b01) ? 2 : 1;
        int          b      = int'(addr[9:0]);
        logic [31:0] r      = '0;
        for (int k = 0; k < nbytes; k++) r[8*k +: 8] = mdl[sel][(b + k) % 1024];
        return r;
    endfunction

    task automatic model_store(input int sel, input logic [1:0] size,
                               input logic [31:0] addr, input logic [31:0] wdata);
        int nbytes = (size == 2'b00) ? 4 : (size == 2'b01) ? 2 : 1;
        int b      = int'(addr[9:0]);
        for (int k = 0; k < nbytes; k++) mdl[sel][(b + k) % 1024] = wdata[8*k +: 8];
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int sel, input logic req, input logic wr, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (sel == 0) begin
            ifa.req = req; ifa.wr = wr; ifa.size = size; ifa.addr = addr; ifa.wdata = wdata;
        end else begin
            ifb.req = req; ifb.wr = wr; ifb.size = size; ifb.addr = addr; ifb.wdata = wdata;
        end
    endtask

    function automatic logic get_ack(input int sel);
        return (sel == 0) ? ifa.ack : ifb.ack;
    endfunction

    task automatic chk_idle(input int sel, input string tag);
        chk({tag, " ack"},      32'((sel == 0) ? ifa.ack      : ifb.ack),      32'd0);
        chk({tag, " busy"},     32'((sel == 0) ? ifa.busy     : ifb.busy),     32'd0);
        chk({tag, " addr_err"}, 32'((sel == 0) ? ifa.addr_err : ifb.addr_err), 32'd0);
        chk({tag, " rdata"},    (sel == 0) ? ifa.rdata : ifb.rdata,            32'd0);
    endtask

    // One transaction; req is seen by the edge ending cycle 0, lat is the ack cycle.
    task automatic do_op(input int sel, input string tag, input logic wr, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rd);
        bit   mis     = model_mis(size, addr);
        int   exp_lat = mis ? 1 : ((sel == 0) ? 2 : 0) + 2;
        int   lat     = -1;
        logic err     = 1'b0;
        rd = '0;
        if (mis)      exp_rd[sel] = '0;
        else if (!wr) exp_rd[sel] = model_load(sel, size, addr);
        else          model_store(sel, size, addr, wdata);
        @(negedge clk);
        drive(sel, 1'b1, wr, size, addr, wdata);
        @(posedge clk);
        #1 drive(sel, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (get_ack(sel)) begin
                lat = n;
                rd  = (sel == 0) ? ifa.rdata : ifb.rdata;
                err = (sel == 0) ? ifa.addr_err : ifb.addr_err;
                break;
            end
        end
        chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, " addr_err"}, 32'(err), 32'(mis));
        chk({tag, " rdata"}, rd, exp_rd[sel]);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd;
        logic [31:0] addr;
        int          ackcnt;
        int          ack_at [$];

        rst_a = 1'b1;
        rst_b = 1'b1;
        drive(0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        repeat (3) @(posedge clk);
        #1 rst_a = 1'b0;
        rst_b = 1'b0;
        @(negedge clk);
        chk_idle(0, "reset_a");
        chk_idle(1, "reset_b");

        for (int i = 0; i < 16; i++)
            do_op(0, "preinit", 1'b1, 2'b00, 32'(i * 4), $urandom, rd);

        do_op(0, "st_w_10", 1'b1, 2'b00, 32'h10, 32'hDEAD_BEEF, rd);
        do_op(0, "ld_w_10", 1'b0, 2'b00, 32'h10, 32'd0, rd);
        chk("ld_w_10 const", rd, 32'hDEAD_BEEF);
        do_op(0, "st_b_11", 1'b1, 2'b10, 32'h11, 32'h0000_00AA, rd);
        chk("st_b_11 keeps rdata", rd, 32'hDEAD_BEEF);
        do_op(0, "ld_w_10b", 1'b0, 2'b00, 32'h10, 32'd0, rd);
        chk("ld_w_10b const", rd, 32'hDEAD_AAEF);
        do_op(0, "ld_b_13", 1'b0, 2'b10, 32'h13, 32'd0, rd);
        chk("ld_b_13 const", rd, 32'h0000_00DE);
        do_op(0, "ld_h_12", 1'b0, 2'b01, 32'h12, 32'd0, rd);
        chk("ld_h_12 const", rd, 32'h0000_DEAD);

        do_op(0, "mis_w_12", 1'b0, 2'b00, 32'h12, 32'd0, rd);
        do_op(0, "mis_sz11", 1'b1, 2'b11, 32'h0, 32'h5555_5555, rd);
        do_op(0, "mis_h_13", 1'b1, 2'b01, 32'h13, 32'h0000_7777, rd);
        do_op(0, "ld_w_10c", 1'b0, 2'b00, 32'h10, 32'd0, rd);
        chk("ld_w_10c const", rd, 32'hDEAD_AAEF);

        do_op(0, "st_wrap", 1'b1, 2'b00, 32'h410, 32'h1234_5678, rd);
        do_op(0, "ld_wrap", 1'b0, 2'b00, 32'h010, 32'd0, rd);
        chk("ld_wrap const", rd, 32'h1234_5678);

        for (int i = 0; i < 60; i++) begin
            addr = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 15) << 2)
                 | 32'($urandom_range(0, 3));
            do_op(0, "random", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  addr, $urandom, rd);
        end

        // Reset landing on the ACCESS cycle must drop the store and the ack.
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 2'b00, 32'h20, 32'hFFFF_FFFF);
        @(posedge clk);
        #1 drive(0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
        @(negedge clk);
        chk("abort busy in wait", 32'(ifa.busy), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst_a = 1'b1;
        @(posedge clk);
        #1 rst_a = 1'b0;
        exp_rd[0] = '0;
        @(negedge clk);
        chk_idle(0, "abort");
        ackcnt = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (ifa.ack) ackcnt++;
        end
        chk("abort ack count", 32'(ackcnt), 32'd0);
        do_op(0, "ld_after_abort", 1'b0, 2'b00, 32'h20, 32'd0, rd);

        // A second req during WAIT must be dropped, including its store.
        exp_rd[0] = model_load(0, 2'b00, 32'h24);
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 2'b00, 32'h24, 32'd0);
        @(posedge clk);
        #1 drive(0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 2'b00, 32'h28, 32'hA5A5_A5A5);
        @(posedge clk);
        #1 drive(0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
        ackcnt = 0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (ifa.ack) begin
                ackcnt++;
                chk("busy-req rdata", ifa.rdata, exp_rd[0]);
            end
        end
        chk("busy-req ack count", 32'(ackcnt), 32'd1);
        do_op(0, "ld_28_untouched", 1'b0, 2'b00, 32'h28, 32'd0, rd);

        // Zero wait states: latency 2 and back-to-back acks every 3 cycles.
        do_op(1, "b_st_w_0", 1'b1, 2'b00, 32'h0, 32'hCAFE_F00D, rd);
        do_op(1, "b_ld_w_0", 1'b0, 2'b00, 32'h0, 32'd0, rd);
        chk("b_ld_w_0 const", rd, 32'hCAFE_F00D);
        @(negedge clk);
        drive(1, 1'b1, 1'b0, 2'b00, 32'h0, 32'd0);
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (ifb.ack) begin
                ack_at.push_back(n);
                chk("b_held rdata", ifb.rdata, 32'hCAFE_F00D);
            end
        end
        drive(1, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
        chk("b_held ack count", 32'(ack_at.size()), 32'd4);
        foreach (ack_at[k]) chk("b_held ack cycle", 32'(ack_at[k]), 32'(2 + 3 * k));
        repeat (4) @(negedge clk);
        chk("b_final busy", 32'(ifb.busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
